pipe_elastic_stage: RTL and testbench

PIPE_ELASTIC_STAGE -- requirements
Module: pipe_elastic_stage

---
 rtl/pipe_elastic_stage.sv | 94 +++++++++
 tb/tb_pipe_elastic_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: circular buffer of DEPTH entries with valid/ready on both sides,
// synchronous flush and a backpressure cycle counter. Optional pass-through: PIPE_ELASTIC_BYPASS_EN.
module pipe_elastic_stage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o,
  output logic [31:0]      bp_cycles_o
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [31:0]      bp_cycles;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             store;
  logic             take;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign empty      = (count == '0);
  assign in_ready_o = (count != FULL_CNT);
  assign push       = in_valid_i && in_ready_o && !flush_i;
  assign pop        = out_valid_o && out_ready_i && !flush_i;

`ifdef PIPE_ELASTIC_BYPASS_EN
  // An empty stage forwards the incoming entry straight through; it is only stored if not taken.
  assign bypass      = empty && in_valid_i && out_ready_i && !flush_i;
  assign out_valid_o = !empty || in_valid_i;
  assign out_data_o  = empty ? in_data_i : mem[rd_ptr];
`else
  assign bypass      = 1'b0;
  assign out_valid_o = !empty;
  assign out_data_o  = mem[rd_ptr];
`endif

  assign store = push && !bypass;
  assign take  = pop && !bypass;

  assign count_o     = count;
  assign bp_cycles_o = bp_cycles;

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store) wr_ptr <= next_ptr(wr_ptr);
      if (take)  rd_ptr <= next_ptr(rd_ptr);
      if (store && !take)      count <= count + CW'(1);
      else if (take && !store) count <= count - CW'(1);
    end
  end

  // Flush neither clears nor advances the stall counter; it saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_cycles <= '0;
    end else if (out_valid_o && !out_ready_i && !flush_i && (bp_cycles != '1)) begin
      bp_cycles <= bp_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Scoreboard bench for pipe_elastic_stage: driver queues accepted payloads, a negedge monitor
// checks occupancy, handshakes, stall count and popped data against a queue-based model.
module tb_pipe_elastic_stage;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;
  logic [CW-1:0]    count_o;
  logic [31:0]      bp_cycles_o;

  logic [WIDTH-1:0] expQ[$];
  bit               pendingPush;
  logic [31:0]      modelBp;
  int               checks;
  int               failures;

  pipe_elastic_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .count_o     (count_o),
    .bp_cycles_o (bp_cycles_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs and records the payload in the model if the stage will accept it.
  task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    if (v && !fl && (expQ.size() < DEPTH)) begin
      expQ.push_back(d);
      pendingPush = 1'b1;
    end
  endtask

  // Asynchronous reset between edges: outputs must clear before the next clock edge.
  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_count", 64'(count_o), 64'd0);
    checkOutput("async_reset_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("async_reset_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("async_reset_bp", 64'(bp_cycles_o), 64'd0);
    expQ.delete();
    pendingPush = 1'b0;
    modelBp     = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      int occ;
      bit expValid;
      logic [WIDTH-1:0] head;
      occ      = expQ.size() - int'(pendingPush);
      expValid = (occ != 0);
`ifdef PIPE_ELASTIC_BYPASS_EN
      if (occ == 0 && in_valid_i) expValid = 1'b1;
`endif
      checkOutput("count", 64'(count_o), 64'(occ));
      checkOutput("in_ready", 64'(in_ready_o), 64'(occ != DEPTH));
      checkOutput("out_valid", 64'(out_valid_o), 64'(expValid));
      checkOutput("bp_cycles", 64'(bp_cycles_o), 64'(modelBp));
      if (expValid && out_ready_i && !flush_i) begin
        head = expQ.pop_front();
        checkOutput("out_data", 64'(out_data_o), 64'(head));
      end
      if (expValid && !out_ready_i && !flush_i && (modelBp != 32'hFFFF_FFFF)) modelBp = modelBp + 1;
      if (flush_i) expQ.delete();
      pendingPush = 1'b0;
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    modelBp     = '0;
    pendingPush = 1'b0;
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    #2;
    checkOutput("reset_count", 64'(count_o), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("reset_bp", 64'(bp_cycles_o), 64'd0);

    // Overfill with downstream stalled: the extra entry must be refused.
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, WIDTH'(16'h000A + i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Full with simultaneous push and pop, then drain.
    applyStimulus(1'b1, 16'h0007, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Back-to-back streaming through a non-power-of-two depth.
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Flush with a full buffer and a new input offered in the same cycle.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0077, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Mid-operation reset with two entries held, then a push right after release.
    applyStimulus(1'b1, 16'h0201, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0202, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    pulseReset();
    applyStimulus(1'b1, 16'h0303, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 24) == 0);
      if (i == 700) pulseReset();
    end

    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("final_drained", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
